// File: rtl/framebuffer_writer.sv
// framebuffer_writer: packs an RGB565 pixel stream into 64-bit words, buffers them
// in a first-word-fall-through FIFO and writes them to PSRAM in fixed-size bursts.
//
// Ports:
//   i_psram_clk, i_psram_rst            clock, synchronous active-high reset
//   i_reg_base_addr                     frame start address (16-bit pixel units)
//   i_frame_start, i_flush              one-cycle control pulses
//   i_pixel_valid/o_pixel_ready/i_pixel_data   pixel stream handshake
//   o_psram_req, i_psram_gnt, o_psram_addr     arbiter request/grant, burst address
//   i_psram_data_req, o_psram_data             controller pops FIFO head word
//   o_busy                              any data buffered or a burst in progress
module framebuffer_writer #(
    parameter int unsigned FIFO_WORDS  = 16,
    parameter int unsigned BURST_WORDS = 8
) (
    input  logic        i_psram_clk,
    input  logic        i_psram_rst,
    input  logic [20:0] i_reg_base_addr,
    input  logic        i_frame_start,
    input  logic        i_flush,
    input  logic        i_pixel_valid,
    output logic        o_pixel_ready,
    input  logic [15:0] i_pixel_data,
    output logic        o_psram_req,
    input  logic        i_psram_gnt,
    output logic [20:0] o_psram_addr,
    input  logic        i_psram_data_req,
    output logic [63:0] o_psram_data,
    output logic        o_busy
);

    localparam int unsigned ADDR_W    = 21;
    localparam int unsigned PTR_W     = $clog2(FIFO_WORDS);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned BEAT_W    = $clog2(BURST_WORDS);
    localparam int unsigned BURST_PIX = BURST_WORDS * 4;
    localparam int unsigned PIX_W     = $clog2(BURST_PIX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t             state;
    logic [63:0]        mem [FIFO_WORDS];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [47:0]        pack_word;
    logic [1:0]         lane;
    logic [PIX_W-1:0]   bpc;
    logic               padding;
    logic               pending;
    logic [BEAT_W-1:0]  beat;

    logic               fifo_full;
    logic               take_pix;
    logic               take_pad;
    logic               pack_en;
    logic [15:0]        pix_in;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   count_nxt;
    logic [1:0]         lane_nxt;
    logic [PIX_W-1:0]   bpc_pk;
    logic               fs_apply;
    logic               pad_nxt;
    logic               pend_nxt;
    logic               go_req;
    logic               burst_done;
    logic               busy_nxt;
    logic               ready_nxt;

    // Datapath decode and next-cycle values for the registered status outputs
    always_comb begin
        fifo_full  = (count == CNT_W'(FIFO_WORDS));
        take_pix   = i_pixel_valid & o_pixel_ready;
        // Padding obeys the same full-FIFO stall as real pixels
        take_pad   = padding & ~fifo_full;
        pack_en    = take_pix | take_pad;
        pix_in     = take_pad ? 16'h0000 : i_pixel_data;
        push       = pack_en & (lane == 2'd3);
        pop        = (state == ST_XFER) & i_psram_data_req & (count != '0);
        count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
        lane_nxt   = pack_en ? lane + 2'd1 : lane;
        bpc_pk     = pack_en ? bpc + PIX_W'(1) : bpc;
        // Frame start waits until every buffered pixel of the old frame is written
        fs_apply   = pending & (state == ST_IDLE) & (count == '0) & (lane == 2'd0) & ~padding;
        // Padding runs until the burst-pixel counter wraps; flush at a boundary is a no-op
        pad_nxt    = (padding | i_flush) & (bpc_pk != '0);
        pend_nxt   = i_frame_start | (pending & ~fs_apply);
        go_req     = (state == ST_IDLE) & (count >= CNT_W'(BURST_WORDS));
        burst_done = (state == ST_XFER) & pop & (beat == BEAT_W'(BURST_WORDS - 1));
        busy_nxt   = (count_nxt != '0) | (lane_nxt != 2'd0) | go_req | (state == ST_REQ) |
                     ((state == ST_XFER) & ~burst_done);
        ready_nxt  = (count_nxt != CNT_W'(FIFO_WORDS)) & ~pad_nxt & ~pend_nxt;
    end

    // FIFO storage; fourth pixel of a word bypasses the pack register
    always_ff @(posedge i_psram_clk) begin
        if (push) begin
            mem[wr_ptr] <= {pix_in, pack_word};
        end
    end

    assign o_psram_data = mem[rd_ptr];

    // Control state, packer, FIFO pointers and burst FSM
    always_ff @(posedge i_psram_clk) begin
        if (i_psram_rst) begin
            state         <= ST_IDLE;
            o_psram_req   <= 1'b0;
            o_psram_addr  <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            pack_word     <= '0;
            lane          <= 2'd0;
            bpc           <= '0;
            padding       <= 1'b0;
            pending       <= 1'b0;
            beat          <= '0;
            o_busy        <= 1'b0;
            o_pixel_ready <= 1'b0;
        end else begin
            count         <= count_nxt;
            lane          <= lane_nxt;
            padding       <= pad_nxt;
            pending       <= pend_nxt;
            o_busy        <= busy_nxt;
            o_pixel_ready <= ready_nxt;
            bpc           <= fs_apply ? '0 : bpc_pk;

            if (pack_en) begin
                case (lane)
                    2'd0:    pack_word[15:0]  <= pix_in;
                    2'd1:    pack_word[31:16] <= pix_in;
                    2'd2:    pack_word[47:32] <= pix_in;
                    default: ;
                endcase
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (go_req) begin
                        state       <= ST_REQ;
                        o_psram_req <= 1'b1;
                    end else if (fs_apply) begin
                        o_psram_addr <= i_reg_base_addr;
                    end
                end
                ST_REQ: begin
                    // Address stays at the burst start through the grant cycle
                    if (i_psram_gnt) begin
                        o_psram_req  <= 1'b0;
                        o_psram_addr <= o_psram_addr + ADDR_W'(BURST_PIX);
                        beat         <= '0;
                        state        <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (pop) begin
                        beat <= beat + BEAT_W'(1);
                        if (burst_done) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Randomized bench for framebuffer_writer: a pixel-stream model builds the expected
// word and burst-address sequences; a controller model grants and pops bursts and
// compares every granted address and popped word.
module tb_framebuffer_writer;

    localparam int BURST = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [20:0] base_addr = '0;
    logic        frame_start = 1'b0;
    logic        flush = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = '0;
    logic        gnt = 1'b0;
    logic        data_req = 1'b0;
    logic        pix_ready;
    logic        req;
    logic [20:0] addr;
    logic [63:0] pdata;
    logic        busy;

    always #5 clk = ~clk;

    framebuffer_writer #(.FIFO_WORDS(16), .BURST_WORDS(8)) dut (
        .i_psram_clk      (clk),
        .i_psram_rst      (rst),
        .i_reg_base_addr  (base_addr),
        .i_frame_start    (frame_start),
        .i_flush          (flush),
        .i_pixel_valid    (pix_valid),
        .o_pixel_ready    (pix_ready),
        .i_pixel_data     (pix_data),
        .o_psram_req      (req),
        .i_psram_gnt      (gnt),
        .o_psram_addr     (addr),
        .i_psram_data_req (data_req),
        .o_psram_data     (pdata),
        .o_busy           (busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pixel stream grouped into words and 32-pixel bursts
    logic [15:0] cur_pix[$];
    logic [63:0] exp_word_q[$];
    logic [20:0] exp_addr_q[$];
    int          m_bpc = 0;
    logic [20:0] m_next_addr = '0;
    logic [20:0] gnt_log[$];
    logic [63:0] word_log[$];

    // Controller / driver state
    int          cst = 0;
    int          beats = 0;
    int          pause_at = -1;
    bit          hold_gnt = 1'b0;
    bit          stray_req = 1'b0;
    int          pix_left = 0;
    bit          pix_seq = 1'b0;
    logic [15:0] pix_next = '0;
    bit          want_flush = 1'b0;
    bit          want_fs = 1'b0;
    bit          defer_flush = 1'b0;
    logic [20:0] fs_base = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_push(input logic [15:0] p);
        cur_pix.push_back(p);
        if (cur_pix.size() == 4) begin
            exp_word_q.push_back({cur_pix[3], cur_pix[2], cur_pix[1], cur_pix[0]});
            cur_pix.delete();
        end
        m_bpc++;
        if (m_bpc == 32) begin
            m_bpc = 0;
            exp_addr_q.push_back(m_next_addr);
            m_next_addr = m_next_addr + 21'd32;
        end
    endfunction

    function automatic void model_flush();
        int n;
        n = (32 - m_bpc) % 32;
        for (int i = 0; i < n; i++) model_push(16'h0000);
    endfunction

    // One cycle: at the falling edge, check outputs and set inputs for the next rising edge
    task automatic tick();
        logic [15:0] d;
        @(negedge clk);
        frame_start = 1'b0;
        flush       = 1'b0;
        gnt         = 1'b0;
        data_req    = 1'b0;
        pix_valid   = 1'b0;

        if (cst == 0) begin
            if (req && !hold_gnt && ($urandom_range(2) == 0)) begin
                gnt = 1'b1;
                total++;
                if (exp_addr_q.size() == 0) begin
                    bad++;
                    $display("FAIL burst_addr: unexpected request at addr %h", addr);
                end else begin
                    total--;
                    chk("burst_addr", 64'(addr), 64'(exp_addr_q.pop_front()));
                end
                gnt_log.push_back(addr);
                cst   = 1;
                beats = 0;
            end else if (!req && ($urandom_range(7) == 0)) begin
                gnt = 1'b1;
            end
            if (!gnt && ($urandom_range(5) == 0)) data_req = 1'b1;
        end else begin
            chk("req_low_in_xfer", 64'(req), 64'd0);
            if ($urandom_range(7) == 0) gnt = 1'b1;
            if (beats != pause_at && ($urandom_range(1) == 0)) begin
                data_req = 1'b1;
                total++;
                if (exp_word_q.size() == 0) begin
                    bad++;
                    $display("FAIL burst_word: unexpected pop of %h", pdata);
                end else begin
                    total--;
                    chk("burst_word", pdata, exp_word_q.pop_front());
                end
                word_log.push_back(pdata);
                beats++;
                if (beats == BURST) cst = 0;
            end
        end
        if (stray_req) data_req = 1'b1;

        if (pix_left > 0 && ($urandom_range(3) != 0)) begin
            d = pix_seq ? pix_next : 16'($urandom);
            pix_valid = 1'b1;
            pix_data  = d;
            if (pix_ready) begin
                model_push(d);
                pix_left--;
                pix_next = pix_next + 16'd1;
            end
        end else begin
            pix_data = 16'($urandom);
        end

        if (want_flush) begin
            flush = 1'b1;
            model_flush();
        end
        if (want_fs) begin
            frame_start = 1'b1;
            base_addr   = fs_base;
            m_bpc       = 0;
            m_next_addr = fs_base;
        end
        want_flush = 1'b0;
        want_fs    = 1'b0;
    endtask

    // Frame start, n pixels, then flush now (1), flush with next frame start (2) or none (0)
    task automatic seg(input logic [20:0] b, input int n, input bit seq, input logic [15:0] first,
                       input int fmode, output int low_cycles);
        int cyc;
        low_cycles = 0;
        if (defer_flush) begin
            want_flush  = 1'b1;
            defer_flush = 1'b0;
        end
        want_fs = 1'b1;
        fs_base = b;
        tick();
        pix_seq  = seq;
        pix_next = first;
        pix_left = n;
        cyc = 0;
        while (pix_left > 0 && cyc < 4000) begin
            tick();
            cyc++;
        end
        if (pix_left > 0) begin
            total++;
            bad++;
            $display("FAIL seg_pixels: %0d pixels not accepted, required 0", pix_left);
            pix_left = 0;
        end
        if (fmode == 1) begin
            want_flush = 1'b1;
            tick();
            tick();
            cyc = 0;
            while (!pix_ready && cyc < 200) begin
                low_cycles++;
                tick();
                cyc++;
            end
        end else if (fmode == 2) begin
            defer_flush = 1'b1;
        end
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while ((exp_word_q.size() != 0 || exp_addr_q.size() != 0 || cst != 0 || busy) && cyc < 3000) begin
            tick();
            cyc++;
        end
        total++;
        if (cyc >= 3000) begin
            bad++;
            $display("FAIL drain: words_left=%0d addrs_left=%0d busy=%0b, required all zero",
                     exp_word_q.size(), exp_addr_q.size(), busy);
        end
    endtask

    initial begin
        int lc, ga, b0, n, mode, cyc;
        logic [20:0] b;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_req", 64'(req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_ready", 64'(pix_ready), 64'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 64'(pix_ready), 64'd1);

        // Single burst with known pixel values
        ga = gnt_log.size(); b0 = word_log.size();
        seg(21'h000100, 32, 1'b1, 16'h0000, 0, lc);
        drain();
        chk("first_gnt_addr", 64'(gnt_log[ga]), 64'h000100);
        chk("first_word", word_log[b0], 64'h0003_0002_0001_0000);
        chk("last_word", word_log[b0+7], 64'h001F_001E_001D_001C);
        chk("next_addr", 64'(addr), 64'h000120);
        chk("idle_busy", 64'(busy), 64'd0);

        // Grant withheld: FIFO fills, ready drops, nothing lost
        hold_gnt = 1'b1; ga = gnt_log.size();
        seg(21'h000200, 64, 1'b0, 16'h0000, 0, lc);
        tick();
        chk("ready_low_full", 64'(pix_ready), 64'd0);
        repeat (5) tick();
        chk("ready_still_low", 64'(pix_ready), 64'd0);
        hold_gnt = 1'b0;
        drain();
        chk("held_addr0", 64'(gnt_log[ga]), 64'h000200);
        chk("held_addr1", 64'(gnt_log[ga+1]), 64'h000220);

        // Partial burst flush
        ga = gnt_log.size(); b0 = word_log.size();
        seg(21'h000300, 5, 1'b1, 16'h0010, 1, lc);
        chk("pad_ready_low_cycles", 64'(lc), 64'd27);
        drain();
        chk("flush_addr", 64'(gnt_log[ga]), 64'h000300);
        chk("flush_word0", word_log[b0], 64'h0013_0012_0011_0010);
        chk("flush_word1", word_log[b0+1], 64'h0000_0000_0000_0014);
        chk("flush_word7", word_log[b0+7], 64'h0);

        // Address wrap at the top of PSRAM
        ga = gnt_log.size();
        seg(21'h1FFFE0, 64, 1'b0, 16'h0000, 0, lc);
        drain();
        chk("wrap_addr0", 64'(gnt_log[ga]), 64'h1FFFE0);
        chk("wrap_addr1", 64'(gnt_log[ga+1]), 64'h000000);

        // Frame start while previous bursts still in flight
        ga = gnt_log.size();
        seg(21'h000500, 64, 1'b0, 16'h0000, 0, lc);
        seg(21'h000400, 32, 1'b0, 16'h0000, 0, lc);
        drain();
        chk("fs_mid_addr0", 64'(gnt_log[ga]), 64'h000500);
        chk("fs_mid_addr1", 64'(gnt_log[ga+1]), 64'h000520);
        chk("fs_mid_addr2", 64'(gnt_log[ga+2]), 64'h000400);

        // Flush and frame start in the same cycle
        ga = gnt_log.size(); b0 = word_log.size();
        seg(21'h000600, 13, 1'b1, 16'h0100, 2, lc);
        seg(21'h000640, 32, 1'b0, 16'h0000, 0, lc);
        drain();
        chk("flush_fs_addr0", 64'(gnt_log[ga]), 64'h000600);
        chk("flush_fs_addr1", 64'(gnt_log[ga+1]), 64'h000640);
        chk("flush_fs_word3", word_log[b0+3], 64'h0000_0000_0000_010C);

        // Random frames
        for (int s = 0; s < 12; s++) begin
            n = $urandom_range(100, 1);
            if (n % 32 != 0) mode = (s == 11) ? 1 : $urandom_range(2, 1);
            else             mode = (s == 11) ? 0 : $urandom_range(2, 0);
            b = 21'($urandom) & 21'h1FFFE0;
            seg(b, n, 1'b0, 16'h0000, mode, lc);
        end
        drain();

        // Reset in the middle of a burst
        pause_at = 3;
        seg(21'h000700, 32, 1'b1, 16'h0000, 0, lc);
        cyc = 0;
        while (!(cst == 1 && beats == 3) && cyc < 2000) begin
            tick();
            cyc++;
        end
        total++;
        if (cyc >= 2000) begin
            bad++;
            $display("FAIL mid_burst_wait: beats=%0d, required 3", beats);
        end
        rst = 1'b1;
        cst = 0; beats = 0; pause_at = -1;
        exp_word_q.delete(); exp_addr_q.delete(); cur_pix.delete();
        m_bpc = 0; m_next_addr = '0;
        tick();
        chk("mid_rst_req", 64'(req), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_addr", 64'(addr), 64'd0);
        stray_req = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) begin
            tick();
            chk("no_req_after_rst", 64'(req), 64'd0);
            chk("no_busy_after_rst", 64'(busy), 64'd0);
        end
        stray_req = 1'b0;
        ga = gnt_log.size();
        seg(21'h000800, 32, 1'b0, 16'h0000, 0, lc);
        drain();
        chk("post_rst_addr", 64'(gnt_log[ga]), 64'h000800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/framebuffer_writer.md
FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

Interface
REQ-001 Parameter FIFO_WORDS, default 16, depth of 64-bit write FIFO (power of 2, >= 8).
REQ-002 Parameter BURST_WORDS, default 8, 64-bit words per PSRAM write burst (= 32 pixels).
REQ-003 i_psram_clk  in  1  sole clock; all logic on rising edge.
REQ-004 i_psram_rst  in  1  reset, synchronous, active-high.
REQ-005 i_reg_base_addr  in  21  frame start address in PSRAM (16-bit pixel units, 32-aligned).
REQ-006 i_frame_start  in  1  one-cycle pulse: next frame begins at i_reg_base_addr.
REQ-007 i_flush  in  1  one-cycle pulse: pad and write out any partial burst.
REQ-008 i_pixel_valid / o_pixel_ready / i_pixel_data  in/out/in  1/1/16  RGB565 pixel stream, transfer when valid & ready.
REQ-009 o_psram_req  out  1  write request to PSRAM arbiter.
REQ-010 i_psram_gnt  in  1  one-cycle grant pulse; address sampled this cycle.
REQ-011 o_psram_addr  out  21  burst start address.
REQ-012 i_psram_data_req  in  1  controller pops one 64-bit word this cycle.
REQ-013 o_psram_data  out  64  FIFO head word, valid whenever FIFO non-empty (first-word-fall-through).
REQ-014 o_busy  out  1  high when FIFO non-empty, packer non-empty, or state != IDLE.

Function
REQ-015 Packer shall place pixels little-endian into 64-bit word: pixel 0 in [15:0], pixel 3 in [63:48]; 4th pixel pushes word to FIFO same cycle.
REQ-016 o_pixel_ready shall be low when FIFO full (count == FIFO_WORDS), while padding, or while frame-start pending; else high.
REQ-017 A burst-pixel counter (0..31) shall track pixels packed in current burst; wraps to 0 after 32.
REQ-018 On i_flush with burst-pixel counter != 0, packer shall insert 16'h0000 pixels (ready low, one per cycle, same FIFO-full stall rule) until counter wraps; with counter == 0 flush is a no-op.
REQ-019 State machine: IDLE, REQ, XFER.
REQ-020 IDLE -> REQ when FIFO count >= BURST_WORDS; o_psram_req set 1 on that transition (registered).
REQ-021 REQ: o_psram_req held 1 until i_psram_gnt; on gnt o_psram_req cleared next cycle, o_psram_addr += 32 (21-bit wrap), state -> XFER.
REQ-022 o_psram_addr value during the gnt cycle shall be the burst start address.
REQ-023 XFER: each i_psram_data_req pops FIFO head; after BURST_WORDS pops state -> IDLE.
REQ-024 i_psram_data_req outside XFER, or in XFER with FIFO empty, shall be ignored (no pop, no underflow).
REQ-025 Simultaneous push and pop in one cycle shall leave count unchanged; FIFO pointers wrap mod FIFO_WORDS.
REQ-026 i_frame_start shall set a pending flag; when pending, state IDLE, FIFO empty and packer empty: o_psram_addr <= i_reg_base_addr, burst-pixel counter <= 0, flag cleared.
REQ-027 i_frame_start while not busy shall take effect the next cycle (one-cycle ready gap).
REQ-028 i_flush and i_frame_start in the same cycle: flush padding completes, then frame start applies.
REQ-029 i_psram_gnt while not in REQ shall be ignored.

Reset
REQ-030 i_psram_rst high: state IDLE, o_psram_req 0, o_psram_addr 0, FIFO/packer/counters empty, pending flags 0, o_busy 0, o_pixel_ready 0 during reset, 1 the cycle after release.
REQ-031 Reset mid-burst shall abandon the burst; no further req or pops until new data.

Verification
REQ-032 Reset, base=0x000100, frame_start, 32 pixels 0x0000..0x001F -> one req; gnt -> addr 0x000100 in gnt cycle; 8 pops, first word 64'h0003_0002_0001_0000; next addr 0x000120.
REQ-033 Hold i_psram_gnt low, push 64 pixels -> ready low after 64th pixel (16 words), no data lost; release gnt -> two bursts, addresses base, base+32.
REQ-034 Push 5 pixels then i_flush -> 27 zero pixels padded, ready low 27 cycles, one burst with words 1..7 upper lanes zero as applicable.
REQ-035 base=0x1FFFE0, 64 pixels -> burst addresses 0x1FFFE0 then 0x000000 (wrap).
REQ-036 i_frame_start mid-transfer with base=0x000400 -> current bursts finish at old addresses; next burst at 0x000400.
REQ-037 Assert i_psram_rst during XFER after 3 pops -> next cycle req 0, busy 0, addr 0; extra data_req causes no pop.
